// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - instruction memory req/ack handshake between fetch and imem
// One request is outstanding at a time; imem_ack completes it.
interface if_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - MIPS IF stage: PC register, imem fetch FSM, IF/ID register and skid buffer
// IF_DELAY_SLOT_EN selects branch-delay-slot redirects; undefined squashes younger fetches.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_bpc,
  input  logic [31:0]       redirect_pc,
  if_fetch_if.master        imem,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_inst
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_FULL} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic        disc_q, disc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        skid_v_q, skid_v_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic        ifv_q, ifv_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] ifinst_q, ifinst_d;

  logic        rd_slot, rd_past, squash;
  logic        ack, disc_now, pend_now, keep, to_ifid;
  logic [31:0] tgt_now;

`ifdef IF_DELAY_SLOT_EN
  assign rd_slot = redirect_valid && (pc_q == redirect_bpc + 32'd4);
  assign rd_past = redirect_valid && (pc_q == redirect_bpc + 32'd8);
  assign squash  = 1'b0;
`else
  logic unused_bpc;
  assign unused_bpc = ^redirect_bpc;
  assign rd_slot    = 1'b0;
  assign rd_past    = redirect_valid;
  assign squash     = redirect_valid;
`endif

  assign ack = req_q & imem.imem_ack;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    disc_d      = disc_q;
    tgt_d       = tgt_q;
    skid_v_d    = skid_v_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    ifv_d       = ifv_q;
    ifpc_d      = ifpc_q;
    ifinst_d    = ifinst_q;

    // A redirect arriving in the same cycle as the ack must already steer this ack.
    disc_now = disc_q | (rd_past & req_q);
    pend_now = pend_q | rd_slot;
    tgt_now  = redirect_valid ? redirect_pc : tgt_q;
    keep     = ack & ~disc_now;
    to_ifid  = ~ifv_q | (~stall & ~skid_v_q);

    if (ack) begin
      pc_d   = (disc_now | pend_now) ? tgt_now : pc_q + 32'd4;
      pend_d = 1'b0;
      disc_d = 1'b0;
    end else begin
      pend_d = pend_now;
      disc_d = disc_now;
      tgt_d  = tgt_now;
      if (rd_past && !req_q) begin
        pc_d = redirect_pc;
      end
    end

    if (!stall) begin
      skid_v_d = 1'b0;
    end
    if (keep && !to_ifid) begin
      skid_v_d    = 1'b1;
      skid_pc_d   = pc_q;
      skid_inst_d = imem.imem_rdata;
    end

    if (!stall) begin
      if (skid_v_q) begin
        ifv_d    = 1'b1;
        ifpc_d   = skid_pc_q;
        ifinst_d = skid_inst_q;
      end else if (keep) begin
        ifv_d    = 1'b1;
        ifpc_d   = pc_q;
        ifinst_d = imem.imem_rdata;
      end else begin
        ifv_d = 1'b0;
      end
    end else if (!ifv_q && keep) begin
      ifv_d    = 1'b1;
      ifpc_d   = pc_q;
      ifinst_d = imem.imem_rdata;
    end

    if (squash) begin
      skid_v_d = 1'b0;
      ifv_d    = 1'b0;
    end

    case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: if (ack && skid_v_d) state_d = S_FULL;
      S_FULL:  if (!skid_v_d) state_d = S_FETCH;
      default: state_d = S_BOOT;
    endcase
    req_d = (state_d == S_FETCH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_BOOT;
      req_q       <= 1'b0;
      pc_q        <= RESET_PC;
      pend_q      <= 1'b0;
      disc_q      <= 1'b0;
      tgt_q       <= 32'h0;
      skid_v_q    <= 1'b0;
      skid_pc_q   <= 32'h0;
      skid_inst_q <= 32'h0;
      ifv_q       <= 1'b0;
      ifpc_q      <= 32'h0;
      ifinst_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      disc_q      <= disc_d;
      tgt_q       <= tgt_d;
      skid_v_q    <= skid_v_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      ifv_q       <= ifv_d;
      ifpc_q      <= ifpc_d;
      ifinst_q    <= ifinst_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign if_valid       = ifv_q;
  assign if_pc          = ifpc_q;
  assign if_inst        = ifinst_q;

endmodule
